morse_letter_scheduler: RTL

//  Queues letter codes (0-7) from a producer and sequences the Morse letter transmitter one letter at a time.

---
 rtl/morse_letter_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/morse_letter_scheduler.sv
// Morse letter scheduler: in-order letter FIFO feeding a START / WAIT_DONE / GAP sequencer.
// Define MORSE_TIMEOUT_EN to enable the TxDone watchdog and the sticky Error flag.
module morse_letter_scheduler #(
   parameter int CLOCK_FREQUENCY = 8,
   parameter int DEPTH           = 4,
   parameter int GAP_TICKS       = 3,
   parameter int TIMEOUT_TICKS   = 30
) (
   input  logic                   ClockIn,
   input  logic                   Reset,
   input  logic                   InValid,
   input  logic [2:0]             InLetter,
   output logic                   InReady,
   output logic                   TxStart,
   output logic [2:0]             TxLetter,
   input  logic                   TxDone,
   output logic                   Busy,
   output logic [$clog2(DEPTH):0] Count,
   output logic                   Error,
   output logic [1:0]             debug_state
);

   localparam int HALF = CLOCK_FREQUENCY / 2;
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int MAXT = (GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS;
   localparam int TW   = $clog2(MAXT + 2);

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [2:0]     mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [HW-1:0]  tick_cnt;
   logic [TW-1:0]  tick_num;
   logic           push;
   logic           pop;
   logic           tick_clr;
   logic           tick_last;
   logic           gap_done;
   logic           timeout;
   logic           error_set;

   // Handshake: a letter transfers on every edge where InValid and InReady are both
   // high; InLetter is don't-care otherwise. InReady depends only on registered Count.
   assign InReady     = (Count != CW'(DEPTH));
   assign push        = InValid & InReady;
   assign pop         = (state == START);
   assign TxStart     = (state == START);
   assign Busy        = (state != IDLE) | (Count != '0);
   assign debug_state = state;

   assign tick_last = (tick_cnt == HW'(HALF - 1));
   assign gap_done  = (GAP_TICKS == 0) || (tick_last && (tick_num == TW'(GAP_TICKS - 1)));
`ifdef MORSE_TIMEOUT_EN
   assign timeout   = tick_last && (tick_num == TW'(TIMEOUT_TICKS - 1));
`else
   assign timeout   = 1'b0;
`endif

   always_ff @(posedge ClockIn) begin
      if (push) mem[wr_ptr] <= InLetter;
   end

   always_ff @(posedge ClockIn) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         Count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      Count <= Count + CW'(1);
         else if (!push && pop) Count <= Count - CW'(1);
      end
   end

   always_ff @(posedge ClockIn) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tick_clr  = 1'b0;
      error_set = 1'b0;
      case (state)
         IDLE: begin
            if (Count != '0) state_nxt = START;
         end
         START: begin
            state_nxt = WAIT_DONE;
            tick_clr  = 1'b1;
         end
         WAIT_DONE: begin
            // TxDone takes priority over a watchdog expiry on the same edge
            if (TxDone) begin
               state_nxt = GAP;
               tick_clr  = 1'b1;
            end else if (timeout) begin
               state_nxt = GAP;
               tick_clr  = 1'b1;
               error_set = 1'b1;
            end
         end
         GAP: begin
            if (gap_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ClockIn) begin
      if (Reset || tick_clr) begin
         tick_cnt <= '0;
         tick_num <= '0;
      end else if (state == WAIT_DONE || state == GAP) begin
         if (tick_last) begin
            tick_cnt <= '0;
            tick_num <= tick_num + TW'(1);
         end else begin
            tick_cnt <= tick_cnt + HW'(1);
         end
      end
   end

   // Head letter is latched on entry to START so it is valid alongside the TxStart pulse.
   always_ff @(posedge ClockIn) begin
      if (Reset)                           TxLetter <= '0;
      else if (state == IDLE && Count != '0) TxLetter <= mem[rd_ptr];
   end

   always_ff @(posedge ClockIn) begin
      if (Reset)          Error <= 1'b0;
      else if (error_set) Error <= 1'b1;
   end

endmodule
